trng_uart_streamer: RTL and testbench

Parametrised successor to the fixed 8-bit random-byte UART path.
- Samples NSRC raw entropy bits on a programmable sample tick and XOR-folds them into one bit per tick.
- Optionally applies von Neumann debiasing, then packs the bits into bytes.
- Buffers bytes in a FIFO and streams them out as 8N1 UART at a parametrised baud rate.
- Sits between the entropy sources (LFSR taps / ring-oscillator bits) and the board TxD pin.

---
 rtl/trng_uart_streamer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_trng_uart_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_uart_streamer.sv
// trng_uart_streamer
// Folds NSRC entropy bits into one bit per sample tick, optionally debiases
// them (von Neumann), packs MSB-first into bytes, buffers the bytes in a
// small FIFO and streams them out as 8N1 UART frames on TxD.
module trng_uart_streamer #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int NSRC       = 4,
    parameter int SAMPLE_DIV = 1000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NSRC-1:0]               src,
    input  logic                          en,
    input  logic                          debias,
    input  logic                          clr_ovf,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int SCW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW       = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ---------------- sampling / bit generation / packer ----------------
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           tick_s;
    logic           raw_bit_s;
    logic           pair_live_s;
    logic           pair_valid_q, pair_valid_d;
    logic           pair_bit_q, pair_bit_d;
    logic           debias_q, debias_d;
    logic           bit_valid_s;
    logic           bit_val_s;
    logic [7:0]     pack_q, pack_d;
    logic [2:0]     pcnt_q, pcnt_d;
    logic           wr_q, wr_d;

    // ---------------- FIFO ----------------
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;
    logic           rd_s;
    logic           full_s;
    logic           wr_ok_s;
    logic           drop_s;
    logic [7:0]     rd_data_s;

    // ---------------- UART ----------------
    state_t         state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;

    // Sample tick divider: counts while enabled, wraps at SAMPLE_DIV-1.
    always_comb begin
        scnt_d = scnt_q;
        tick_s = 1'b0;
        if (en) begin
            if (scnt_q == SCW'(SAMPLE_DIV - 1)) begin
                scnt_d = {SCW{1'b0}};
                tick_s = 1'b1;
            end else begin
                scnt_d = scnt_q + SCW'(1);
            end
        end else begin
            scnt_d = {SCW{1'b0}};
        end
    end

    // Entropy bit: XOR fold, then either raw or von Neumann pair evaluation.
    always_comb begin
        raw_bit_s    = ^src;
        debias_d     = debias;
        // A mode change forgets any half-collected pair.
        pair_live_s  = pair_valid_q & (debias == debias_q);
        pair_valid_d = pair_live_s;
        pair_bit_d   = pair_bit_q;
        bit_valid_s  = 1'b0;
        bit_val_s    = 1'b0;
        if (!en) begin
            pair_valid_d = 1'b0;
        end else if (tick_s) begin
            if (debias) begin
                if (pair_live_s) begin
                    pair_valid_d = 1'b0;
                    // 01 -> 0, 10 -> 1: the emitted bit equals the first of the pair.
                    if (pair_bit_q != raw_bit_s) begin
                        bit_valid_s = 1'b1;
                        bit_val_s   = pair_bit_q;
                    end else begin
                        bit_valid_s = 1'b0;
                    end
                end else begin
                    pair_valid_d = 1'b1;
                    pair_bit_d   = raw_bit_s;
                end
            end else begin
                bit_valid_s = 1'b1;
                bit_val_s   = raw_bit_s;
            end
        end else begin
            pair_valid_d = pair_live_s;
        end
    end

    // Packer: MSB-first shift, raises a one-cycle write strobe on the 8th bit.
    always_comb begin
        pack_d = pack_q;
        pcnt_d = pcnt_q;
        wr_d   = 1'b0;
        if (!en) begin
            pcnt_d = 3'd0;
        end else if (bit_valid_s) begin
            pack_d = {pack_q[6:0], bit_val_s};
            if (pcnt_q == 3'd7) begin
                pcnt_d = 3'd0;
                wr_d   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 3'd1;
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // FIFO bookkeeping: read is the UART pop, a full write only lands if a pop frees a slot.
    always_comb begin
        rd_s       = (state_q == ST_IDLE) && (level_q != {LW{1'b0}});
        full_s     = (level_q == LW'(FIFO_DEPTH));
        wr_ok_s    = wr_q && (!full_s || rd_s);
        drop_s     = wr_q && full_s && !rd_s;
        rd_data_s  = mem_q[rptr_q];
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (wr_ok_s) begin
            mem_d[wptr_q] = pack_q;
            wptr_d        = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_ok_s, rd_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A new drop wins over a clear in the same cycle.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // UART next-state: IDLE pops, then START/DATA/STOP each held BAUD_DIV cycles.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                bcnt_d = {BCW{1'b0}};
                bidx_d = 3'd0;
                if (rd_s) begin
                    shift_d = rd_data_s;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bcnt_q == BCW'(BAUD_DIV - 1)) begin
                    bcnt_d  = {BCW{1'b0}};
                    state_d = ST_DATA;
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            ST_DATA: begin
                if (bcnt_q == BCW'(BAUD_DIV - 1)) begin
                    bcnt_d = {BCW{1'b0}};
                    if (bidx_q == 3'd7) begin
                        bidx_d  = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            ST_STOP: begin
                if (bcnt_q == BCW'(BAUD_DIV - 1)) begin
                    bcnt_d  = {BCW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                bcnt_d  = {BCW{1'b0}};
                bidx_d  = 3'd0;
            end
        endcase
    end

    // UART line and busy: registered one cycle behind the state so TxD falls the edge after the pop.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_q != ST_IDLE);
        case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[bidx_q];
            ST_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers with asynchronous clear; an interrupted frame is abandoned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt_q       <= {SCW{1'b0}};
            pair_valid_q <= 1'b0;
            pair_bit_q   <= 1'b0;
            debias_q     <= 1'b0;
            pack_q       <= 8'h00;
            pcnt_q       <= 3'd0;
            wr_q         <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q       <= {AW{1'b0}};
            rptr_q       <= {AW{1'b0}};
            level_q      <= {LW{1'b0}};
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            bcnt_q       <= {BCW{1'b0}};
            bidx_q       <= 3'd0;
            shift_q      <= 8'h00;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            scnt_q       <= scnt_d;
            pair_valid_q <= pair_valid_d;
            pair_bit_q   <= pair_bit_d;
            debias_q     <= debias_d;
            pack_q       <= pack_d;
            pcnt_q       <= pcnt_d;
            wr_q         <= wr_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            bidx_q       <= bidx_d;
            shift_q      <= shift_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
        end
    end

    assign TxD        = txd_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_trng_uart_streamer.sv
// Directed bench for trng_uart_streamer: a UART receiver model pops expected
// bytes from a scoreboard queue filled as stimulus is driven; timing and
// flag checks are made inline at known cycle offsets.
module tb_trng_uart_streamer;

    localparam int CLK_HZ     = 1000;
    localparam int BAUD       = 100;
    localparam int NSRC       = 4;
    localparam int SAMPLE_DIV = 2;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] src = 4'b0000;
    logic       en = 1'b0;
    logic       debias = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       TxD;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    logic [7:0]  sb[$];
    int unsigned starts[$];
    int unsigned cyc = 0;

    trng_uart_streamer #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NSRC(NSRC),
        .SAMPLE_DIV(SAMPLE_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src(src), .en(en), .debias(debias),
        .clr_ovf(clr_ovf), .TxD(TxD), .busy(busy), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy !== 1'b0 || fifo_level !== 3'd0 || sb.size() != 0) && n < 3000) begin
            step(1);
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
        step(2);
    endtask

    // UART receiver model: samples mid-bit on the falling clock edge.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_active <= 1'b0;
            mon_cnt    <= 0;
        end else if (!mon_active) begin
            if (TxD === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt + 1 == 5) check("rx_start_bit", 32'(TxD), 32'd0);
            if ((mon_cnt + 1) >= 15 && (mon_cnt + 1) <= 85 && ((mon_cnt + 1) % 10) == 5)
                mon_byte[((mon_cnt + 1) / 10) - 1] <= TxD;
            if (mon_cnt + 1 == 95) begin
                check("rx_stop_bit", 32'(TxD), 32'd1);
                check("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("rx_byte", 32'(mon_byte), 32'(sb.pop_front()));
                mon_active <= 1'b0;
            end
        end
    end

    initial begin
        int n;
        int zeros;

        // Reset state
        step(3);
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        step(2);

        // 1. Raw all-ones: one 0xFF frame, 2-cycle write-to-start latency, 100-cycle busy
        sb.push_back(8'hFF);
        src = 4'b0001; debias = 1'b0; en = 1'b1;
        step(16);
        en = 1'b0;
        check("t1_level_p16", 32'(fifo_level), 32'd0);
        step(1);
        check("t1_level_p17", 32'(fifo_level), 32'd1);
        step(1);
        check("t1_level_p18", 32'(fifo_level), 32'd0);
        check("t1_txd_p18", 32'(TxD), 32'd1);
        check("t1_busy_p18", 32'(busy), 32'd0);
        step(1);
        check("t1_txd_p19", 32'(TxD), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 9)  check("t1_start_end", 32'(TxD), 32'd0);
            if (n == 10) check("t1_data0", 32'(TxD), 32'd1);
            if (n == 99) check("t1_stop_last", 32'(TxD), 32'd1);
            step(1);
            n++;
        end
        check("t1_busy_len", 32'(n), 32'd100);
        wait_idle("t1_idle");

        // 2. Raw alternating pattern -> 0xAA, LSB first on the line
        sb.push_back(8'hAA);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            src = (i % 2 == 0) ? 4'b0111 : 4'b0011;
            step(2);
        end
        en = 1'b0;
        step(1);
        check("t2_level_p17", 32'(fifo_level), 32'd1);
        step(2);
        check("t2_txd_start", 32'(TxD), 32'd0);
        step(15);
        check("t2_bit0", 32'(TxD), 32'd0);
        step(10);
        check("t2_bit1", 32'(TxD), 32'd1);
        wait_idle("t2_idle");

        // 3. Von Neumann: pairs 01,10,11,00 x4 -> 0x55, written after tick 28
        debias = 1'b1;
        step(2);
        sb.push_back(8'h55);
        en = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            case ((t - 1) % 8)
                1, 2, 4, 5: src = 4'b0001;
                default:    src = 4'b0000;
            endcase
            step(1);
            if (t == 29) check("t3_level_p57", 32'(fifo_level), 32'd1);
            step(1);
            if (t == 28) check("t3_level_p56", 32'(fifo_level), 32'd0);
        end
        en = 1'b0;
        step(2);
        debias = 1'b0;
        wait_idle("t3_idle");

        // 6. Enable drop: 5 zero bits discarded, byte needs 8 fresh ticks
        sb.push_back(8'hFF);
        src = 4'b0000; en = 1'b1;
        step(10);
        en = 1'b0;
        step(3);
        src = 4'b0001; en = 1'b1;
        step(7);
        check("t6_level_p20", 32'(fifo_level), 32'd0);
        step(9);
        check("t6_level_p29", 32'(fifo_level), 32'd0);
        en = 1'b0;
        step(1);
        check("t6_level_p30", 32'(fifo_level), 32'd1);
        wait_idle("t6_idle");

        // 4. Overflow: six bytes produced, the sixth is dropped
        starts.delete();
        for (int i = 0; i < 5; i++) sb.push_back(8'hFF);
        src = 4'b0001; en = 1'b1;
        step(81);
        check("t4_level_peak", 32'(fifo_level), 32'd4);
        step(15);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        en = 1'b0;
        step(1);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        check("t4_level_full", 32'(fifo_level), 32'd4);
        step(2);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        wait_idle("t4_idle");
        check("t4_frames", 32'(starts.size()), 32'd5);
        if (starts.size() >= 2) check("t4_period", 32'(starts[1] - starts[0]), 32'd101);

        // 5. Reset during data bit 3, frame never resumes
        sb.push_back(8'hFF);
        src = 4'b0001; en = 1'b1;
        step(32);
        en = 1'b0;
        step(20);
        check("t5_busy_pre", 32'(busy), 32'd1);
        check("t5_level_pre", 32'(fifo_level), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_txd_rst", 32'(TxD), 32'd1);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_level_rst", 32'(fifo_level), 32'd0);
        sb.delete();
        step(2);
        reset_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (TxD !== 1'b1 || busy !== 1'b0) zeros++;
        end
        check("t5_line_idle", 32'(zeros), 32'd0);
        check("t5_level_after", 32'(fifo_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
